// File: rtl/seq_div32_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div32_pkg;

  localparam int DEFAULT_N = 32;
  localparam int CNT_W     = $clog2(DEFAULT_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter width for a given operand width (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_div32_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, select.
module div_step
  import seq_div32_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic [N-1:0] quo_next
);

  logic [N:0]   rem_sh;
  logic [N+1:0] diff;
  logic         unused_hi;

  always_comb begin
    rem_sh   = {rem, quo[N-1]};
    diff     = {1'b0, rem_sh} - {2'b00, divisor};
    quo_next = {quo[N-2:0], ~diff[N+1]};
    // Either surviving value is below the divisor, so bit N is always 0.
    rem_next = diff[N+1] ? rem_sh[N-1:0] : diff[N-1:0];
  end

  assign unused_hi = ^{rem_sh[N], diff[N]};

endmodule

// File: rtl/seq_div32.sv
// Iterative N-bit restoring divider: IDLE -> RUN (N steps) -> FIX -> DONE.
// Define SEQ_DIV32_SIGNED_EN to honour signed_op (two's-complement division).
module seq_div32
  import seq_div32_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         signed_op,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         zero
);

  localparam int CW = cnt_width(N);

  state_t          state_reg, state_next;
  logic [N-1:0]    rem_reg, quo_reg, dvsr_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    quotient_reg, remainder_reg;
  logic            dbz_reg, zero_reg;
  logic [N-1:0]    rem_step, quo_step;
  logic [N-1:0]    a_mag, b_mag, q_fix, r_fix;
  logic            neg_q, neg_r;
  logic            divisor_zero, last_step;

  assign divisor_zero = (divisor == '0);
  assign last_step    = (cnt_reg == CW'(N - 1));

`ifdef SEQ_DIV32_SIGNED_EN
  logic a_neg, b_neg;

  assign a_neg = signed_op & dividend[N-1];
  assign b_neg = signed_op & divisor[N-1];
  assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign neg_q = 1'b0;
  assign neg_r = 1'b0;
`endif

  // Magnitude of -2^(N-1) / -1 is 2^(N-1); negating it wraps back to itself.
  assign q_fix = neg_q ? (~quo_reg + 1'b1) : quo_reg;
  assign r_fix = neg_r ? (~rem_reg + 1'b1) : rem_reg;

  div_step #(.N(N)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (dvsr_reg),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = divisor_zero ? DONE : RUN;
      RUN:  if (last_step) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  // Results are registered on entry to DONE so they are valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvsr_reg      <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      zero_reg      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (divisor_zero) begin
              quotient_reg  <= '1;
              remainder_reg <= dividend;
              dbz_reg       <= 1'b1;
              zero_reg      <= 1'b0;
            end else begin
              quo_reg  <= a_mag;
              rem_reg  <= '0;
              dvsr_reg <= b_mag;
              cnt_reg  <= '0;
            end
          end
        end
        RUN: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: begin
          quotient_reg  <= q_fix;
          remainder_reg <= r_fix;
          dbz_reg       <= 1'b0;
          zero_reg      <= (quo_reg == '0);
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;
  assign zero        = zero_reg;

endmodule

// File: tb/tb_seq_div32.sv
// Self-checking bench for seq_div32: directed cases plus random operands vs. an arithmetic model.
module tb_seq_div32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        signed_op = 1'b0;
  logic        busy, done, div_by_zero, zero;
  logic [31:0] quotient, remainder;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_div32 #(.N(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_op   (signed_op),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference: plain arithmetic on the captured operands.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic dbz);
    longint sa, sb, sq, sr;
    dbz = (b == 0);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
`ifdef SEQ_DIV32_SIGNED_EN
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sq = sa / sb;
        sr = sa % sb;
        q = sq[31:0];
        r = sr[31:0];
      end else begin
        q = a / b;
        r = a % b;
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endtask

  // Runs one division; inject > 0 pulses a second start at that cycle of the run.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int inject);
    logic [31:0] q_exp, r_exp;
    logic        dbz_exp;
    int          cycles, exp_lat, done_cnt;
    model(a, b, s, q_exp, r_exp, dbz_exp);
    exp_lat = (b == 0) ? 1 : 34;
    @(negedge clk);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
    cycles = 0;
    done_cnt = 0;
    while (cycles < 60 && done_cnt == 0) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (done) done_cnt++;
      else if (cycles == inject) begin
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      end
    end
    start = 1'b0;
    chk("latency", 32'(cycles), 32'(exp_lat));
    chk("quotient", quotient, q_exp);
    chk("remainder", remainder, r_exp);
    chk("div_by_zero", 32'(div_by_zero), 32'(dbz_exp));
    chk("zero", 32'(zero), 32'(q_exp == 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    $display("op a=0x%08h b=0x%08h s=%0d -> q=0x%08h r=0x%08h dbz=%0d zero=%0d lat=%0d",
             a, b, s, quotient, remainder, div_by_zero, zero, cycles);
  endtask

  initial begin
    int done_seen;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'd100, 32'd7, 1'b0, 0);
    do_op(32'h0000_1234, 32'd0, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    do_op(32'd3, 32'd5, 1'b0, 0);
    do_op(32'd100, 32'd7, 1'b0, 5);

    // Reset 10 cycles into a division: no done pulse, outputs back to reset values.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_quotient", quotient, 32'd0);
    chk("mid_rst_remainder", remainder, 32'd0);
    chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("no_done_after_rst", 32'(done_seen), 32'd0);
    do_op(32'd9, 32'd3, 1'b0, 0);

    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);

    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 3) rb = 32'd0;
      do_op(ra, rb, 1'($urandom), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_div32.md
SEQ_DIV32 -- requirements
Module: seq_div32

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, meaning request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, N, meaning numerator; captured on the accepted start.
REQ-006 SHALL have port divisor, input, N, meaning denominator; captured on the accepted start.
REQ-007 SHALL have port signed_op, input, 1, meaning two's-complement division request; captured on the accepted start.
REQ-008 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-009 SHALL have port done, output, 1, meaning a one-cycle pulse when the results become valid.
REQ-010 SHALL have port quotient, output, N, meaning the result quotient; held until the next accepted start.
REQ-011 SHALL have port remainder, output, N, meaning the result remainder; held until the next accepted start.
REQ-012 SHALL have port div_by_zero, output, 1, meaning the captured divisor was 0; held with the results.
REQ-013 SHALL have port zero, output, 1, meaning quotient == 0; held with the results.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-015 SHALL accept start in IDLE only; start in any other state is ignored with no side effects.
REQ-016 On an accepted start with divisor != 0, SHALL load operands, clear the partial remainder and iteration counter, and go to RUN.
REQ-017 RUN SHALL perform one restoring step per cycle: shift {rem, quo} left by 1, trial-subtract divisor from rem (N+1-bit difference), keep the difference and set the quotient bit when it is non-negative, otherwise restore.
REQ-018 RUN SHALL last exactly N cycles (counter 0..N-1); the counter terminal count SHALL move the FSM to FIX.
REQ-019 FIX SHALL apply sign correction (see Configuration) and go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, update the result outputs and flags, and return to IDLE.
REQ-021 Latency: start accepted at cycle 0 -> done high at cycle N+2 (cycle 34 for N=32); a new start is accepted the cycle after done.
REQ-022 On divisor == 0, SHALL skip RUN and FIX, go directly to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1, and assert done at cycle 1.
REQ-023 Unsigned results SHALL satisfy dividend == quotient*divisor + remainder with remainder < divisor.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, zero=1, counter=0.
REQ-025 Reset mid-operation SHALL abandon the division with no done pulse; the first accepted start after rst_n rises SHALL behave as from power-up.

Configuration
REQ-026 Macro SEQ_DIV32_SIGNED_EN defined: when signed_op=1, SHALL divide the operand magnitudes, negate the quotient if the operand signs differ, and give the remainder the dividend's sign; the case -2^(N-1) / -1 SHALL yield quotient = 0x80000000 and remainder = 0.
REQ-027 Macro undefined: signed_op SHALL be ignored, the operation SHALL always be unsigned, FIX SHALL still occupy one cycle, and latency SHALL be unchanged.

Structure
REQ-028 Package seq_div32_pkg SHALL hold the FSM state enum, the default width constant, and the counter-width constant $clog2(N).
REQ-029 The single restoring step (shift, trial subtract, select) SHALL be the sub-module div_step, which is combinational and instantiated once inside the iterative loop.

Verification
REQ-030 Unsigned: dividend 100 / divisor 7 -> done at cycle 34, quotient 14, remainder 2, zero 0.
REQ-031 Divide by zero: dividend 0x1234 / divisor 0 -> done at cycle 1, quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero 1.
REQ-032 Unsigned boundary: 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0; 3 / 5 -> quotient 0, remainder 3, zero 1.
REQ-033 Second start pulsed during busy -> ignored; results are those of the first operands; exactly one done pulse.
REQ-034 rst_n asserted at cycle 10 of a division -> all outputs return to reset values and no done pulse occurs; the next operation 9/3 gives quotient 3.
REQ-035 With SEQ_DIV32_SIGNED_EN and signed_op=1: -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
